// File: rtl/render_state_fetch.sv
`default_nettype none
// ============================================================================
// Module   : render_state_fetch
// Brief    : Per-pixel sim-state word fetch and decode for the colour mapper,
//            with VGA timing delayed to stay aligned with the decoded flags.
// Revision : 1.0
// ============================================================================
module render_state_fetch #(
    parameter int CELL_SHIFT  = 2,
    parameter int GRID_XB     = 7,
    parameter int GRID_YB     = 7,
    parameter int SIGNAL_BITS = 10,
    parameter int MEM_LAT     = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       pixel_ce,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       hs_in,
    input  logic                       vs_in,
    input  logic                       blank_n_in,
    input  logic [GRID_XB+GRID_YB-1:0] view_cell,
    input  logic [GRID_XB+GRID_YB-1:0] write_cell,
    output logic                       mem_req,
    output logic [GRID_XB+GRID_YB-1:0] mem_addr,
    input  logic                       mem_gnt,
    input  logic [SIGNAL_BITS+2:0]     mem_rdata,
    output logic                       renderAnt,
    output logic                       renderSugar,
    output logic                       renderNest,
    output logic [SIGNAL_BITS-1:0]     renderSignal,
    output logic                       render_viewLoc,
    output logic                       render_writeLoc,
    output logic                       hs_out,
    output logic                       vs_out,
    output logic                       blank_n_out,
    output logic [15:0]                miss_count
);

    localparam int         c_CELL_W   = GRID_XB + GRID_YB;
    localparam int         c_WORD_W   = SIGNAL_BITS + 3;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_WAIT  = 1'b1;
    localparam logic [1:0] c_LAST_CNT = 2'(MEM_LAT - 1);

    logic [9:0]          w_cx_full;
    logic [9:0]          w_cy_full;
    logic                w_in_grid;
    logic                w_frame_start;
    logic                w_grant;
    logic                w_stale;
    logic [c_WORD_W-1:0] w_s2_word;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [1:0]          r_wait_cnt;
    logic [1:0]          w_wait_cnt_nxt;
    logic                w_capture;

    logic                r_s0_in_grid;
    logic [c_CELL_W-1:0] r_s0_cell;
    logic                r_s1_in_grid;
    logic                r_s1_view_hit;
    logic                r_s1_write_hit;
    logic [c_CELL_W-1:0] r_mem_addr;
    logic [c_WORD_W-1:0] r_last_word;
    logic [c_WORD_W-1:0] r_render_word;
    logic                r_view_loc;
    logic                r_write_loc;
    logic [2:0]          r_hs_pipe;
    logic [2:0]          r_vs_pipe;
    logic [2:0]          r_bl_pipe;
    logic [15:0]         r_miss_count;

    // Grid test uses the full shifted coordinate so wrapped cells are rejected.
    assign w_cx_full     = DrawX >> CELL_SHIFT;
    assign w_cy_full     = DrawY >> CELL_SHIFT;
    assign w_in_grid     = ((w_cx_full >> GRID_XB) == 10'd0) &&
                           ((w_cy_full >> GRID_YB) == 10'd0);
    assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

    // Request rides the S1 beat itself so the word is back before S2.
    assign mem_req  = pixel_ce & r_s0_in_grid;
    assign mem_addr = mem_req ? r_s0_cell : r_mem_addr;
    assign w_grant  = mem_req & mem_gnt;
    assign w_stale  = mem_req & ~mem_gnt;

    assign w_s2_word = r_s1_in_grid ? r_last_word : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt    = c_ST_WAIT;
                    w_wait_cnt_nxt = 2'd0;
                end
            end
            c_ST_WAIT: begin
                if (r_wait_cnt == c_LAST_CNT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s0_in_grid   <= 1'b0;
            r_s0_cell      <= '0;
            r_s1_in_grid   <= 1'b0;
            r_s1_view_hit  <= 1'b0;
            r_s1_write_hit <= 1'b0;
            r_mem_addr     <= '0;
            r_last_word    <= '0;
            r_render_word  <= '0;
            r_view_loc     <= 1'b0;
            r_write_loc    <= 1'b0;
            r_hs_pipe      <= 3'b111;
            r_vs_pipe      <= 3'b111;
            r_bl_pipe      <= 3'b000;
            r_miss_count   <= 16'd0;
        end else begin
            if (w_capture) begin
                r_last_word <= mem_rdata;
            end
            if (mem_req) begin
                r_mem_addr <= r_s0_cell;
            end
            if (pixel_ce) begin
                r_s0_in_grid   <= w_in_grid;
                r_s0_cell      <= {w_cy_full[GRID_YB-1:0], w_cx_full[GRID_XB-1:0]};
                r_s1_in_grid   <= r_s0_in_grid;
                r_s1_view_hit  <= r_s0_in_grid && (r_s0_cell == view_cell);
                r_s1_write_hit <= r_s0_in_grid && (r_s0_cell == write_cell);
                r_render_word  <= w_s2_word;
                r_view_loc     <= r_s1_view_hit;
                r_write_loc    <= r_s1_write_hit;
                r_hs_pipe      <= {r_hs_pipe[1:0], hs_in};
                r_vs_pipe      <= {r_vs_pipe[1:0], vs_in};
                r_bl_pipe      <= {r_bl_pipe[1:0], blank_n_in};
                // Frame-start clear takes priority over a same-beat miss.
                if (w_frame_start) begin
                    r_miss_count <= 16'd0;
                end else if (w_stale && (r_miss_count != 16'hFFFF)) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    assign renderAnt       = r_render_word[0];
    assign renderNest      = r_render_word[1];
    assign renderSugar     = r_render_word[2];
    assign renderSignal    = r_render_word[c_WORD_W-1:3];
    assign render_viewLoc  = r_view_loc;
    assign render_writeLoc = r_write_loc;
    assign hs_out          = r_hs_pipe[2];
    assign vs_out          = r_vs_pipe[2];
    assign blank_n_out     = r_bl_pipe[2];
    assign miss_count      = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_render_state_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_render_state_fetch
// Brief    : Randomized bench for render_state_fetch against a beat-level model.
// Revision : 1.0
// ============================================================================
module tb_render_state_fetch;

    localparam int CELL_SHIFT  = 2;
    localparam int GRID_XB     = 7;
    localparam int GRID_YB     = 7;
    localparam int SIGNAL_BITS = 10;
    localparam int MEM_LAT     = 1;

    typedef struct packed {
        logic       live;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
    } pix_t;

    typedef struct packed {
        logic       ant;
        logic       sugar;
        logic       nest;
        logic [9:0] sig;
        logic       view;
        logic       wloc;
        logic       hs;
        logic       vs;
        logic       bl;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pixel_ce;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        blank_n_in;
    logic [13:0] view_cell;
    logic [13:0] write_cell;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_gnt;
    logic [12:0] mem_rdata;
    logic        renderAnt;
    logic        renderSugar;
    logic        renderNest;
    logic [9:0]  renderSignal;
    logic        render_viewLoc;
    logic        render_writeLoc;
    logic        hs_out;
    logic        vs_out;
    logic        blank_n_out;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] mem_arr [0:16383];
    logic        pend_req  = 1'b0;
    logic [13:0] pend_addr = 14'd0;
    logic        rsp_valid = 1'b0;
    logic [13:0] rsp_addr  = 14'd0;
    logic [12:0] junk      = 13'd0;

    res_t        exp_q [$];
    pix_t        prev_pix;
    logic [12:0] m_last;
    logic [15:0] m_miss;

    render_state_fetch #(
        .CELL_SHIFT (CELL_SHIFT),
        .GRID_XB    (GRID_XB),
        .GRID_YB    (GRID_YB),
        .SIGNAL_BITS(SIGNAL_BITS),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .pixel_ce       (pixel_ce),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .hs_in          (hs_in),
        .vs_in          (vs_in),
        .blank_n_in     (blank_n_in),
        .view_cell      (view_cell),
        .write_cell     (write_cell),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rdata      (mem_rdata),
        .renderAnt      (renderAnt),
        .renderSugar    (renderSugar),
        .renderNest     (renderNest),
        .renderSignal   (renderSignal),
        .render_viewLoc (render_viewLoc),
        .render_writeLoc(render_writeLoc),
        .hs_out         (hs_out),
        .vs_out         (vs_out),
        .blank_n_out    (blank_n_out),
        .miss_count     (miss_count)
    );

    always #5 Clk = ~Clk;

    // Memory responder: data for a granted request is valid the next clock only.
    always @(negedge Clk) begin
        pend_req  = mem_req & mem_gnt;
        pend_addr = mem_addr;
    end
    always @(posedge Clk) begin
        rsp_valid <= pend_req;
        rsp_addr  <= pend_addr;
        junk      <= 13'($urandom);
    end
    assign mem_rdata = rsp_valid ? mem_arr[rsp_addr] : junk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_in_grid(input pix_t p);
        return p.live && ((int'(p.x) / (1 << CELL_SHIFT)) < (1 << GRID_XB)) &&
               ((int'(p.y) / (1 << CELL_SHIFT)) < (1 << GRID_YB));
    endfunction

    function automatic logic [13:0] m_cell(input pix_t p);
        int cx;
        int cy;
        cx = (int'(p.x) / (1 << CELL_SHIFT)) % (1 << GRID_XB);
        cy = (int'(p.y) / (1 << CELL_SHIFT)) % (1 << GRID_YB);
        return 14'(cy * (1 << GRID_XB) + cx);
    endfunction

    task automatic model_reset();
        res_t r;
        r = '0;
        r.hs = 1'b1;
        r.vs = 1'b1;
        exp_q.delete();
        exp_q.push_back(r);
        prev_pix    = '0;
        prev_pix.hs = 1'b1;
        prev_pix.vs = 1'b1;
        m_last = 13'd0;
        m_miss = 16'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_flags"}, 32'({renderAnt, renderSugar, renderNest, render_viewLoc, render_writeLoc}), 32'd0);
        check_eq({tag, "_signal"}, 32'(renderSignal), 32'd0);
        check_eq({tag, "_sync"}, 32'({hs_out, vs_out, blank_n_out}), 32'b110);
        check_eq({tag, "_miss"}, 32'(miss_count), 32'd0);
        check_eq({tag, "_req"}, 32'({mem_req, mem_addr}), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after gap clocks.
    task automatic do_beat(input logic [9:0] px, input logic [9:0] py, input logic phs,
                           input logic pvs, input logic pbl, input logic gnt, input int gap);
        pix_t        cur;
        res_t        r;
        res_t        o;
        bit          ig;
        logic [13:0] c;
        logic [12:0] w;
        cur.live = 1'b1;
        cur.x    = px;
        cur.y    = py;
        cur.hs   = phs;
        cur.vs   = pvs;
        cur.bl   = pbl;
        DrawX = px;  DrawY = py;  hs_in = phs;  vs_in = pvs;  blank_n_in = pbl;
        mem_gnt = gnt;  pixel_ce = 1'b1;
        ig = m_in_grid(prev_pix);
        c  = m_cell(prev_pix);
        @(negedge Clk);
        check_eq("mem_req", 32'(mem_req), 32'(ig));
        if (ig) check_eq("mem_addr", 32'(mem_addr), 32'(c));
        if (!ig)      w = 13'd0;
        else if (gnt) w = mem_arr[c];
        else          w = m_last;
        if (ig && gnt) m_last = mem_arr[c];
        r.ant   = w[0];
        r.nest  = w[1];
        r.sugar = w[2];
        r.sig   = w[12:3];
        r.view  = ig && (c == view_cell);
        r.wloc  = ig && (c == write_cell);
        r.hs    = prev_pix.hs;
        r.vs    = prev_pix.vs;
        r.bl    = prev_pix.bl;
        if (px == 10'd0 && py == 10'd0) m_miss = 16'd0;
        else if (ig && !gnt && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        exp_q.push_back(r);
        prev_pix = cur;
        @(posedge Clk);
        #1;
        pixel_ce = 1'b0;
        mem_gnt  = 1'b0;
        o = exp_q.pop_front();
        check_eq("flags", 32'({renderAnt, renderSugar, renderNest, render_viewLoc, render_writeLoc}),
                 32'({o.ant, o.sugar, o.nest, o.view, o.wloc}));
        check_eq("signal", 32'(renderSignal), 32'(o.sig));
        check_eq("sync", 32'({hs_out, vs_out, blank_n_out}), 32'({o.hs, o.vs, o.bl}));
        check_eq("miss", 32'(miss_count), 32'(m_miss));
        repeat (gap - 1) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rx;
        logic [9:0] ry;
        for (int i = 0; i < 16384; i++) mem_arr[i] = 13'($urandom);
        Reset = 1'b1;  pixel_ce = 1'b0;  DrawX = '0;  DrawY = '0;
        hs_in = 1'b1;  vs_in = 1'b1;  blank_n_in = 1'b0;  mem_gnt = 1'b0;
        view_cell = '0;  write_cell = 14'h3FFF;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_reset_state("reset");
        Reset = 1'b0;

        // Cell 0 word decode and repeated same-cell fetches.
        mem_arr[0] = 13'h405;
        for (int i = 0; i < 6; i++) begin
            do_beat(10'(i), 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2);
            if (i == 2) begin
                check_eq("dir_signal", 32'(renderSignal), 32'h080);
                check_eq("dir_ant", 32'(renderAnt), 32'd1);
            end
        end

        // View / write location match at cell {1,2}.
        view_cell  = 14'h082;
        write_cell = 14'h0FF;
        do_beat(10'd8, 10'd4, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        do_beat(10'd100, 10'd40, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        do_beat(10'd104, 10'd40, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        check_eq("dir_viewloc", 32'({render_viewLoc, render_writeLoc}), 32'b10);

        // Out-of-grid pixel.
        do_beat(10'd600, 10'd100, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        do_beat(10'd4, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        do_beat(10'd8, 10'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3);
        check_eq("dir_oog", 32'({renderAnt, renderSugar, renderNest, renderSignal}), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) view_cell = m_cell(prev_pix);
            else view_cell = 14'($urandom);
            if ($urandom_range(0, 2) == 0) write_cell = m_cell(prev_pix);
            else write_cell = 14'($urandom);
            rx = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 511)) : 10'($urandom);
            ry = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 511)) : 10'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rx = 10'd0;
                ry = 10'd0;
            end
            do_beat(rx, ry, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 3) != 0), int'($urandom_range(2, 4)));
        end

        // Saturation: preload the counter near the top, then only misses.
        force dut.r_miss_count = 16'hFFF0;
        @(posedge Clk);
        #1;
        release dut.r_miss_count;
        m_miss = 16'hFFF0;
        for (int i = 0; i < 20; i++) begin
            do_beat(10'd20, 10'd20, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        end
        check_eq("miss_sat", 32'(miss_count), 32'hFFFF);
        do_beat(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        check_eq("miss_clear", 32'(miss_count), 32'd0);

        // Reset while a granted fetch is in WAIT; the returning word must be dropped.
        mem_arr[m_cell(prev_pix)] = 13'h1FFF;
        do_beat(10'd40, 10'd40, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_state("midwait");
        Reset = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        do_beat(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        do_beat(10'd44, 10'd44, 1'b1, 1'b1, 1'b1, 1'b0, 2);
        do_beat(10'd48, 10'd44, 1'b1, 1'b1, 1'b1, 1'b1, 2);
        check_eq("abort_word", 32'({renderAnt, renderSugar, renderNest, renderSignal}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            do_beat(10'($urandom_range(0, 600)), 10'($urandom_range(0, 600)), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
